wb_spi_master_fifo: RTL

Wishbone-slave SPI master, successor to the single-byte simple SPI core. Adds parametrised slave-select count, TX/RX FIFOs and full CPOL/CPHA mode support.
Keeps the 8-bit Wishbone register bus and the same external pin set (sck_o, ss_o, mosi_o, miso_i), so it drops into the existing SPI testbench environment.

---
 rtl/wb_spi_master_fifo_pkg.sv | 30 +++
 rtl/wb_spi_master_fifo_if.sv | 22 ++
 rtl/wb_spi_master_fifo_fifo.sv | 53 +++++
 rtl/wb_spi_master_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_master_fifo_pkg.sv
// rtl/wb_spi_master_fifo_pkg.sv - register map, bit indices and FSM states for the SPI master
package wb_spi_pkg;

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_DATA   = 3'd2;
    localparam logic [2:0] ADR_DIV    = 3'd3;
    localparam logic [2:0] ADR_SS     = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_IE      = 3;
    localparam int CTRL_AUTO_SS = 4;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_TX_OVF   = 6;
    localparam int STAT_IRQ      = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/wb_spi_master_fifo_if.sv
// rtl/wb_spi_master_fifo_if.sv - 8-bit Wishbone register bus between host and SPI master
interface wb_spi_master_fifo_if;

    logic       cyc_i;
    logic       stb_i;
    logic [2:0] adr_i;
    logic       we_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic       ack_o;

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, dat_i,
        output dat_o, ack_o
    );

    modport master (
        output cyc_i, stb_i, adr_i, we_i, dat_i,
        input  dat_o, ack_o
    );

endinterface

// File: rtl/wb_spi_master_fifo_fifo.sv
// rtl/wb_spi_master_fifo_fifo.sv - first-word-fallthrough synchronous FIFO with flush
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer update; flush discards everything including a same-cycle push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_spi_master_fifo.sv
// rtl/wb_spi_master_fifo.sv - Wishbone SPI master with TX/RX FIFOs and CPOL/CPHA modes
module wb_spi_master_fifo
    import wb_spi_pkg::*;
#(
    parameter int NUM_SS     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_spi_master_fifo_if.slave bus,
    output logic                inta_o,
    output logic                sck_o,
    output logic [NUM_SS-1:0]   ss_o,
    output logic                mosi_o,
    input  logic                miso_i
);

    logic [4:0]        ctrl_q;
    logic [DIV_W-1:0]  div_q;
    logic [NUM_SS-1:0] ss_q;
    logic              rx_ovf_q, tx_ovf_q, irq_q, inta_q;
    logic              ack_q;
    logic [7:0]        dat_q, rd_data, status;

    spi_state_t        state;
    logic [7:0]        tx_sr, rx_sr;
    logic              sck_q, mosi_q, cpha_l;
    logic [3:0]        half_cnt;
    logic [DIV_W-1:0]  div_cnt, div_l;

    logic              acc, wr, rd, w1c;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]        tx_dout, rx_dout, rx_push_data;
    logic              en, busy, half_end, last_half, drive, sample, abort, start, end_burst;
    logic              rx_ovf_evt, tx_ovf_evt;

    assign acc = bus.cyc_i & bus.stb_i & ~ack_q;
    assign wr  = acc & bus.we_i;
    assign rd  = acc & ~bus.we_i;
    assign w1c = wr && (bus.adr_i == ADR_STATUS);

    assign en        = ctrl_q[CTRL_EN];
    assign busy      = (state == SHIFT);
    assign half_end  = busy && (div_cnt == div_l);
    assign last_half = half_end && (half_cnt == 4'd15);
    // Even half_cnt ends on a leading SCK edge, odd on a trailing one.
    assign drive     = half_end && (cpha_l ? ~half_cnt[0] : half_cnt[0]);
    assign sample    = half_end && (cpha_l ? half_cnt[0] : ~half_cnt[0]);
    assign abort     = busy & ~en;
    assign start     = en & ~tx_empty & (~busy | last_half);
    assign end_burst = last_half & en & tx_empty;

    // In cpha=1 the last bit is sampled on the very edge that completes the byte.
    assign rx_push_data = cpha_l ? {rx_sr[6:0], miso_i} : rx_sr;

    assign tx_push = wr && (bus.adr_i == ADR_DATA);
    assign tx_pop  = start;
    assign rx_push = last_half & en;
    assign rx_pop  = rd && (bus.adr_i == ADR_DATA);

    assign tx_ovf_evt = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_evt = rx_push & rx_full & ~rx_pop;

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (abort),
        .din   (bus.dat_i),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (abort),
        .din   (rx_push_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign status = {irq_q, tx_ovf_q, rx_ovf_q, busy, tx_full, tx_empty, rx_full, rx_empty};

    // Register read multiplexer; an empty RX FIFO reads as zero.
    always_comb begin
        rd_data = 8'h00;
        case (bus.adr_i)
            ADR_CTRL:   rd_data = {3'b000, ctrl_q};
            ADR_STATUS: rd_data = status;
            ADR_DATA:   rd_data = rx_empty ? 8'h00 : rx_dout;
            ADR_DIV:    rd_data = 8'(div_q);
            ADR_SS:     rd_data = 8'(ss_q);
            default:    rd_data = 8'h00;
        endcase
    end

    // Bus termination and registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 8'h00;
        end else begin
            ack_q <= acc;
            if (rd) dat_q <= rd_data;
        end
    end

    // Control registers, sticky flags (set beats clear) and interrupt output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            div_q    <= '0;
            ss_q     <= '0;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
            inta_q   <= 1'b0;
        end else begin
            if (wr && bus.adr_i == ADR_CTRL) ctrl_q <= bus.dat_i[4:0];
            if (wr && bus.adr_i == ADR_DIV)  div_q  <= bus.dat_i[DIV_W-1:0];
            if (wr && bus.adr_i == ADR_SS)   ss_q   <= bus.dat_i[NUM_SS-1:0];
            rx_ovf_q <= (rx_ovf_q & ~(w1c & bus.dat_i[STAT_RX_OVF])) | rx_ovf_evt;
            tx_ovf_q <= (tx_ovf_q & ~(w1c & bus.dat_i[STAT_TX_OVF])) | tx_ovf_evt;
            irq_q    <= (irq_q & ~(w1c & bus.dat_i[STAT_IRQ])) | end_burst | rx_ovf_evt;
            inta_q   <= irq_q & ctrl_q[CTRL_IE];
        end
    end

    // Shift engine: 16 half-periods per byte, mode latched at byte start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            half_cnt <= 4'd0;
            div_cnt  <= '0;
            div_l    <= '0;
            cpha_l   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            sck_q <= ctrl_q[CTRL_CPOL];
        end else if (start) begin
            state    <= SHIFT;
            sck_q    <= ctrl_q[CTRL_CPOL];
            cpha_l   <= ctrl_q[CTRL_CPHA];
            div_l    <= div_q;
            div_cnt  <= '0;
            half_cnt <= 4'd0;
            rx_sr    <= 8'h00;
            if (!ctrl_q[CTRL_CPHA]) begin
                mosi_q <= tx_dout[7];
                tx_sr  <= {tx_dout[6:0], 1'b0};
            end else begin
                tx_sr  <= tx_dout;
            end
        end else if (busy) begin
            if (half_end) begin
                sck_q    <= ~sck_q;
                div_cnt  <= '0;
                half_cnt <= half_cnt + 4'd1;
                if (drive) begin
                    mosi_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
                if (sample) rx_sr <= {rx_sr[6:0], miso_i};
                if (last_half) state <= IDLE;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end else begin
            sck_q <= ctrl_q[CTRL_CPOL];
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
    assign inta_o    = inta_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign ss_o      = (ctrl_q[CTRL_AUTO_SS] && !busy) ? {NUM_SS{1'b1}} : ~ss_q;

endmodule
